// File: rtl/mmio_console.sv
// mmio_console: CPU-mapped byte console with RX/TX FIFOs, sticky EOT/overflow/underflow flags
module mmio_console_fifo #(
  parameter int DEPTH = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    push,
  input  logic                    pop,
  input  logic [7:0]              din,
  output logic [7:0]              dout,
  output logic [$clog2(DEPTH):0]  cnt
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  logic [7:0]    mem [DEPTH];
  logic [PW-1:0] rp, wp;
  always_ff @(posedge clk) if (push && rst) mem[wp] <= din;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rp  <= '0;
      wp  <= '0;
      cnt <= '0;
    end else begin
      if (push) wp <= wp + PW'(1);
      if (pop) rp <= rp + PW'(1);
      cnt <= cnt + CW'(push) - CW'(pop);
    end
  end
  assign dout = mem[rp];
endmodule

module mmio_console #(
  parameter int                    ADDR_WIDTH = 10,
  parameter logic [ADDR_WIDTH-1:0] DATA_ADDR  = 'h01e,
  parameter logic [ADDR_WIDTH-1:0] STAT_ADDR  = 'h01c,
  parameter int                    DEPTH      = 16,
  parameter logic [7:0]            EOT_CHAR   = 8'h04
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic                  wr,
  input  logic                  rd,
  input  logic [15:0]           wr_data,
  output logic [15:0]           rd_data,
  output logic                  sel,
  input  logic                  rx_valid,
  input  logic [7:0]            rx_data,
  output logic                  rx_ready,
  output logic                  tx_valid,
  output logic [7:0]            tx_data,
  input  logic                  tx_ready,
  output logic                  eot
);
  localparam int CW = $clog2(DEPTH) + 1;
  logic [CW-1:0] rx_cnt, tx_cnt;
  logic [7:0]    rx_head, rx_occ;
  logic [31:0]   rx_cnt32;
  logic [15:0]   status;
  logic [2:0]    clr;
  logic is_data, is_stat, rx_full, rx_empty, tx_full, tx_empty;
  logic data_wr, eot_wr, rx_push, rx_pop, tx_push, tx_pop;
  logic set_ovf, set_unf, tx_ovf, rx_unf, unused;

  mmio_console_fifo #(.DEPTH(DEPTH)) u_rx (
    .clk(clk), .rst(rst), .push(rx_push), .pop(rx_pop),
    .din(rx_data), .dout(rx_head), .cnt(rx_cnt)
  );
  mmio_console_fifo #(.DEPTH(DEPTH)) u_tx (
    .clk(clk), .rst(rst), .push(tx_push), .pop(tx_pop),
    .din(wr_data[7:0]), .dout(tx_data), .cnt(tx_cnt)
  );

  assign is_data  = addr == DATA_ADDR;
  assign is_stat  = addr == STAT_ADDR;
  assign sel      = is_data || is_stat;
  assign rx_full  = rx_cnt == CW'(DEPTH);
  assign rx_empty = rx_cnt == '0;
  assign tx_full  = tx_cnt == CW'(DEPTH);
  assign tx_empty = tx_cnt == '0;
  assign rx_ready = !rx_full;
  assign tx_valid = !tx_empty;
  // All full/empty decisions use the pre-edge occupancy, so a same-cycle pop never makes room
  assign data_wr  = wr && is_data && wr_data[7:0] != EOT_CHAR;
  assign eot_wr   = wr && is_data && wr_data[7:0] == EOT_CHAR;
  assign rx_push  = rx_valid && !rx_full;
  assign rx_pop   = rd && is_data && !rx_empty;
  assign tx_push  = data_wr && !tx_full;
  assign tx_pop   = tx_valid && tx_ready;
  assign set_ovf  = data_wr && tx_full;
  assign set_unf  = rd && is_data && rx_empty;
  assign clr      = wr && is_stat ? wr_data[4:2] : 3'b000;
  assign rx_cnt32 = 32'(rx_cnt);
  assign rx_occ   = rx_cnt32 > 32'd255 ? 8'hff : rx_cnt32[7:0];
  assign status   = {rx_occ, 3'b000, rx_unf, tx_ovf, eot, tx_full, !rx_empty};
  assign rd_data  = is_data && rd ? (rx_empty ? 16'h0000 : {8'h00, rx_head}) :
                    is_stat ? status : 16'h0000;
  assign unused   = ^wr_data[15:8];

  // Sticky flags: a set in the same cycle as its W1C wins
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      eot    <= 1'b0;
      tx_ovf <= 1'b0;
      rx_unf <= 1'b0;
    end else begin
      eot    <= eot_wr  || (eot    && !clr[0]);
      tx_ovf <= set_ovf || (tx_ovf && !clr[1]);
      rx_unf <= set_unf || (rx_unf && !clr[2]);
    end
  end
endmodule

// File: tb/tb_mmio_console.sv
// tb_mmio_console: random + directed stimulus checked against a queue-based console model
module tb_mmio_console;
  localparam int DEPTH = 16;
  localparam logic [9:0] DA = 10'h01e;
  localparam logic [9:0] SA = 10'h01c;
  localparam logic [7:0] EOT = 8'h04;

  logic clk = 1'b0;
  logic rst;
  logic [9:0] addr;
  logic wr, rd, rx_valid, tx_ready, rx_ready, tx_valid, sel, eot;
  logic [15:0] wr_data, rd_data;
  logic [7:0] rx_data, tx_data;

  int checks = 0;
  int failures = 0;

  logic [7:0] rx_q[$];
  logic [7:0] tx_q[$];
  bit m_eot, m_ovf, m_unf;

  mmio_console #(.ADDR_WIDTH(10), .DATA_ADDR(DA), .STAT_ADDR(SA), .DEPTH(DEPTH), .EOT_CHAR(EOT)) dut (
    .clk(clk), .rst(rst), .addr(addr), .wr(wr), .rd(rd), .wr_data(wr_data), .rd_data(rd_data),
    .sel(sel), .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready), .eot(eot)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] status_exp();
    int occ;
    occ = rx_q.size() > 255 ? 255 : rx_q.size();
    return {8'(occ), 3'b000, m_unf, m_ovf, m_eot, tx_q.size() == DEPTH, rx_q.size() != 0};
  endfunction

  // Reference model: whole-transaction view of each clock edge
  always @(posedge clk or negedge rst) begin
    bit dsel, ssel, rx_full, rx_emp, tx_full, tx_emp;
    if (!rst) begin
      rx_q.delete();
      tx_q.delete();
      m_eot = 0;
      m_ovf = 0;
      m_unf = 0;
    end else begin
      dsel = addr == DA;
      ssel = addr == SA;
      rx_full = rx_q.size() == DEPTH;
      rx_emp = rx_q.size() == 0;
      tx_full = tx_q.size() == DEPTH;
      tx_emp = tx_q.size() == 0;
      if (!tx_emp && tx_ready) void'(tx_q.pop_front());
      if (rd && dsel && !rx_emp) void'(rx_q.pop_front());
      if (rx_valid && !rx_full) rx_q.push_back(rx_data);
      if (wr && dsel && wr_data[7:0] != EOT && !tx_full) tx_q.push_back(wr_data[7:0]);
      m_eot = (wr && dsel && wr_data[7:0] == EOT) || (m_eot && !(wr && ssel && wr_data[2]));
      m_ovf = (wr && dsel && wr_data[7:0] != EOT && tx_full) || (m_ovf && !(wr && ssel && wr_data[3]));
      m_unf = (rd && dsel && rx_emp) || (m_unf && !(wr && ssel && wr_data[4]));
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      chk("tx_valid", tx_valid, tx_q.size() != 0);
      if (tx_q.size() != 0) chk("tx_data", tx_data, tx_q[0]);
      chk("rx_ready", rx_ready, rx_q.size() < DEPTH);
      chk("eot", eot, m_eot);
      chk("sel", sel, addr == DA || addr == SA);
      if (addr == SA) chk("status", rd_data, status_exp());
      else if (addr == DA && rd) chk("rd_data", rd_data, rx_q.size() != 0 ? {8'h00, rx_q[0]} : 16'h0000);
      else if (addr != DA) chk("rd_zero", rd_data, 16'h0000);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr = 0;
    rd = 0;
  endtask

  task automatic set_wr(input logic [9:0] a, input logic [15:0] d);
    addr = a;
    wr = 1;
    rd = 0;
    wr_data = d;
  endtask

  task automatic set_rd(input logic [9:0] a);
    addr = a;
    rd = 1;
    wr = 0;
  endtask

  initial begin
    int n, pushed, rd_n, r, bias;
    logic [7:0] last;
    bit acc;
    rst = 0; wr = 0; rd = 0; addr = '0; wr_data = '0;
    rx_valid = 0; rx_data = '0; tx_ready = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_rx_ready", rx_ready, 1);
    chk("rst_tx_valid", tx_valid, 0);
    chk("rst_eot", eot, 0);
    rst = 1;
    step();

    // Two CPU bytes stream out back to back
    tx_ready = 1;
    set_wr(DA, 16'h0041);
    step();
    wr_data = 16'h0042;
    @(negedge clk);
    chk("t033_first", tx_data, 8'h41);
    step();
    idle();
    @(negedge clk);
    chk("t033_second", tx_data, 8'h42);
    chk("t033_valid", tx_valid, 1);
    step();
    @(negedge clk);
    chk("t033_empty", tx_valid, 0);

    // TX overflow, drop, W1C
    tx_ready = 0;
    for (int i = 0; i <= DEPTH; i++) begin
      set_wr(DA, 16'(8'h50 + i));
      step();
    end
    set_rd(SA);
    @(negedge clk);
    chk("t034_stat", rd_data, 16'h000a);
    step();
    idle();
    tx_ready = 1;
    n = 0;
    last = 0;
    repeat (DEPTH + 3) begin
      @(negedge clk);
      if (tx_valid) begin
        last = tx_data;
        n++;
      end
      step();
    end
    chk("t034_count", n, DEPTH);
    chk("t034_last", last, 8'h50 + DEPTH - 1);
    tx_ready = 0;
    set_wr(SA, 16'h0008);
    step();
    set_rd(SA);
    @(negedge clk);
    chk("t034_w1c", rd_data, 16'h0000);
    step();
    idle();

    // Host to CPU, underflow
    for (int i = 0; i < 4; i++) begin
      rx_valid = 1;
      rx_data = 8'h30 + 8'(i);
      step();
    end
    rx_valid = 0;
    set_rd(SA);
    @(negedge clk);
    chk("t035_stat", rd_data, 16'h0401);
    step();
    set_rd(DA);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("t035_read", rd_data, 16'h0030 + 16'(i));
      step();
    end
    @(negedge clk);
    chk("t035_unf_read", rd_data, 16'h0000);
    step();
    set_rd(SA);
    @(negedge clk);
    chk("t035_unf_stat", rd_data, 16'h0010);
    step();
    set_wr(SA, 16'h0010);
    step();
    idle();

    // EOT byte sets the flag without queueing
    set_wr(DA, 16'h0077);
    step();
    set_wr(DA, 16'h0004);
    @(negedge clk);
    chk("t036_valid_pre", tx_valid, 1);
    step();
    set_rd(SA);
    @(negedge clk);
    chk("t036_eot", eot, 1);
    chk("t036_valid", tx_valid, 1);
    chk("t036_stat", rd_data, 16'h0004);
    step();
    set_wr(SA, 16'h0004);
    step();
    idle();
    @(negedge clk);
    chk("t036_clr", eot, 0);
    tx_ready = 1;
    step();
    step();
    tx_ready = 0;

    // Same-cycle push into empty RX and read: read sees empty, byte survives
    rx_valid = 1;
    rx_data = 8'ha5;
    set_rd(DA);
    @(negedge clk);
    chk("t026_rx_empty", rd_data, 16'h0000);
    step();
    rx_valid = 0;
    @(negedge clk);
    chk("t026_rx_kept", rd_data, 16'h00a5);
    step();
    set_wr(SA, 16'h0010);
    step();

    // Write to full TX with same-cycle pop still drops
    for (int i = 0; i < DEPTH; i++) begin
      set_wr(DA, 16'(8'hc0 + i));
      step();
    end
    tx_ready = 1;
    set_wr(DA, 16'h00ee);
    step();
    tx_ready = 0;
    set_rd(SA);
    @(negedge clk);
    chk("t026_tx_drop", rd_data, 16'h0008);
    step();
    set_wr(SA, 16'h0008);
    step();
    idle();
    tx_ready = 1;
    n = 0;
    last = 0;
    repeat (DEPTH + 2) begin
      @(negedge clk);
      if (tx_valid) begin
        last = tx_data;
        n++;
      end
      step();
    end
    chk("t026_tx_count", n, DEPTH - 1);
    chk("t026_tx_last", last, 8'hc0 + DEPTH - 1);
    tx_ready = 0;

    // Full RX drained one read per cycle with rx_valid held
    rx_valid = 1;
    for (int i = 0; i < DEPTH; i++) begin
      rx_data = 8'h80 + 8'(i);
      step();
    end
    pushed = DEPTH;
    rd_n = 0;
    rx_data = 8'(8'h80 + pushed);
    set_rd(DA);
    for (int k = 0; k < DEPTH + 4; k++) begin
      @(negedge clk);
      if (k == 0) chk("t037_full", rx_ready, 0);
      if (k == 1) chk("t037_rise", rx_ready, 1);
      chk("t037_data", rd_data, {8'h00, 8'(8'h80 + rd_n)});
      acc = rx_ready;
      step();
      rd_n++;
      if (acc) begin
        pushed++;
        rx_data = 8'(8'h80 + pushed);
      end
    end
    rx_valid = 0;
    for (int g = 0; g < 64 && rd_n < pushed; g++) begin
      @(negedge clk);
      chk("t037_tail", rd_data, {8'h00, 8'(8'h80 + rd_n)});
      step();
      rd_n++;
    end
    set_rd(SA);
    @(negedge clk);
    chk("t037_stat", rd_data, 16'h0000);
    step();
    idle();

    // Asynchronous reset mid-stream
    for (int i = 0; i < 3; i++) begin
      set_wr(DA, 16'(8'h61 + i));
      step();
    end
    idle();
    rx_valid = 1;
    rx_data = 8'h99;
    tx_ready = 1;
    chk("t038_pre", tx_valid, 1);
    #2;
    rst = 0;
    #1;
    chk("t038_tx_valid", tx_valid, 0);
    chk("t038_rx_ready", rx_ready, 1);
    chk("t038_eot", eot, 0);
    @(posedge clk);
    @(negedge clk);
    rx_valid = 0;
    tx_ready = 0;
    rst = 1;
    step();
    set_rd(SA);
    @(negedge clk);
    chk("t038_stat", rd_data, 16'h0000);
    step();
    idle();

    // Randomized traffic, alternating fill-biased and drain-biased phases
    for (int c = 0; c < 3000; c++) begin
      bias = (c / 250) % 2;
      r = $urandom_range(0, 9);
      addr = r < 5 ? DA : r < 8 ? SA : 10'($urandom_range(0, 1023));
      wr = $urandom_range(0, 3) == 0;
      rd = bias != 0 ? $urandom_range(0, 1) == 0 : $urandom_range(0, 4) == 0;
      wr_data = addr == SA ? 16'($urandom) : ($urandom_range(0, 15) == 0 ? 16'h0004 : 16'($urandom));
      rx_valid = bias != 0 ? $urandom_range(0, 3) == 0 : $urandom_range(0, 1) == 0;
      rx_data = 8'($urandom);
      tx_ready = bias != 0 ? $urandom_range(0, 1) == 0 : $urandom_range(0, 5) == 0;
      step();
    end
    idle();
    rx_valid = 0;
    step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
